bk_kbd_regs: RTL and testbench
==============================

// Module: bk_kbd_regs
// PURPOSE
//   Bus-side keyboard register stage, directly upstream of the CPU bus OR-mux and of the vector interrupt controller.
//   Buffers decoded key codes from the PS/2 translator in a small FIFO.
//   Exposes BK register 177660 (status/mask) and register 177662 (data).
//   Raises the vector-60 / vector-274 (AR2) requests to the interrupt controller.
// PARAMETERS
//   FIFO_DEPTH  4  key-code entries; power of two, 2..16
// PORTS
//   clk_sys        in   1   system clock; all logic on posedge
//   reset_n        in   1   asynchronous active-low reset
//   ce_bus         in   1   CPU bus clock enable
//   bus_sync       in   1   address phase valid
//   bus_addr       in   16  bus address
//   bus_we         in   1   write cycle
//   bus_wtbt       in   2   byte strobes [1]=high, [0]=low
//   bus_stb        in   1   data strobe (DIN|DOUT)
//   bus_din        in   16  write data from CPU
//   bus_dout       out  16  read data; 0 when not selected (OR-bus)
//   bus_ack        out  1   reply
//   key_valid      in   1   new key code strobe (1 clk)
//   key_code       in   7   key code
//   key_ar2        in   1   key pressed with AR2 -> vector 274
//   key_ready      out  1   FIFO can accept a push
//   virq_req60     out  1   interrupt request, vector 060
//   virq_req274    out  1   interrupt request, vector 274
//   virq_ack60     in   1   vector 060 taken (1 clk)
//   virq_ack274    in   1   vector 274 taken (1 clk)
// BEHAVIOUR
//   Reset: all outputs 0, key_ready 1, FIFO empty, mask bit 0, pending requests 0.
//   Decode: sel660/sel662 latched while bus_sync & bus_addr[15:1] matches; dropped when bus_sync falls.
//   Ack timing:
//     - bus_ack rises on the first ce_bus with bus_stb & sel (1 ce latency).
//     - bus_ack falls on the first ce_bus after bus_stb drops.
//   Read 177660: {8'0, rdy, mask, 6'0}.
//     - rdy = FIFO not empty.
//     - mask = interrupt disable (1 = off).
//   Read 177662: {9'0, head code}; 0 when empty.
//     - Pop occurs once, on falling bus_stb of the read (data stable for the whole cycle).
//   Write 177660: mask <= bus_din[6] when bus_wtbt[0]; high byte ignored.
//   Write 177662: ignored, but bus_ack is still given.
//   Push: key_valid & !full stores {ar2,code}; key_valid & full drops the code.
//     - key_ready = !full, from the count only; a pop in the same cycle does not admit a full push.
//   Same-cycle push & pop on a non-full, non-empty FIFO: both occur, count unchanged.
//   Pointers wrap modulo FIFO_DEPTH; count is $clog2(FIFO_DEPTH)+1 bits.
//   IRQ:
//     - Pending is set when the head becomes valid (empty->nonempty or pop leaving nonempty) and mask=0.
//     - Head ar2 routes it to req274, otherwise to req60; exactly one request is active at a time.
//     - Cleared by the matching ack, by the 177662 read pop, or by writing mask=1.
//     - Clearing mask while rdy=1 re-raises the request next clk.
//   reset_n low mid-cycle: FIFO flushed, bus_ack drops immediately, requests drop.
// CONFIGURATION
//   `define KBD_OVERRUN_EN
//     - Sticky overrun flag, bit 15 of 177660.
//     - Set when key_valid arrives while full.
//     - Cleared on completion (stb fall) of a 177660 read.
//   Without it: bit 15 reads 0; overflowing keys are silently dropped.
// STRUCTURE
//   Package bk_kbd_pkg:
//     - KBD_CSR_ADDR=16'o177660, KBD_DATA_ADDR=16'o177662.
//     - VEC_KBD=16'o000060, VEC_KBD_AR2=16'o000274.
//     - typedef kbd_entry_t {logic ar2; logic [6:0] code;}.
//   Sub-module kbd_fifo: storage, pointers and count.
//     - Exposes head/empty/full; push/pop inputs.
//   Top level holds decode, ack, mask, IRQ and overrun logic.
// TESTING
//   1. Push code 7'o101 (ar2=0), mask=0.
//      -> 177660 reads 16'o000200; virq_req60=1; read 177662 = 16'o000101.
//      -> After the stb fall, rdy=0 and req60=0.
//   2. Push 7'o012 with ar2=1.
//      -> virq_req274=1, req60=0; virq_ack274 pulse clears it; data still readable.
//   3. Write 177660=16'o000100, then push a key.
//      -> No request, rdy=1. Write 0 -> req60 asserts next clk.
//   4. Push FIFO_DEPTH+1 keys 1..5 (depth 4).
//      -> key_ready=0 after 4; reads return 1,2,3,4 then rdy=0.
//      -> With KBD_OVERRUN_EN, 177660 bit15=1, then 0 after that read.
//   5. key_valid on the same clk as the stb fall of a 177662 read, count 2.
//      -> count stays 2, order preserved.
//   6. Assert reset_n low during a 177662 read.
//      -> bus_ack, requests and rdy at 0 immediately; no stale data after release.

Source files
------------

// File: rtl/bk_kbd_pkg.sv
// ============================================================================
// bk_kbd_pkg : shared addresses, vectors and FIFO entry type for the keyboard
// Rev 1.0
// ============================================================================
`default_nettype none

package bk_kbd_pkg;

  localparam logic [15:0] KBD_CSR_ADDR  = 16'o177660;
  localparam logic [15:0] KBD_DATA_ADDR = 16'o177662;
  localparam logic [15:0] VEC_KBD       = 16'o000060;
  localparam logic [15:0] VEC_KBD_AR2   = 16'o000274;

  typedef struct packed {
    logic       ar2;
    logic [6:0] code;
  } kbd_entry_t;

endpackage

`default_nettype wire

// File: rtl/bk_kbd_regs_fifo.sv
// ============================================================================
// kbd_fifo : key-code FIFO with wrap-around pointers and an occupancy count
// Rev 1.0
// ============================================================================
`default_nettype none

module kbd_fifo
  import bk_kbd_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       push,
  input  kbd_entry_t push_data,
  input  logic       pop,
  output kbd_entry_t head,
  output logic       empty,
  output logic       full
);

  localparam int                 C_PTR_W   = $clog2(FIFO_DEPTH);
  localparam logic [C_PTR_W-1:0] C_PTR_ONE = 1;
  localparam logic [C_PTR_W:0]   C_CNT_ONE = 1;
  localparam logic [C_PTR_W:0]   C_FULL    = FIFO_DEPTH[C_PTR_W:0];

  kbd_entry_t         r_mem [FIFO_DEPTH];
  logic [C_PTR_W-1:0] r_wr_ptr;
  logic [C_PTR_W-1:0] r_rd_ptr;
  logic [C_PTR_W:0]   r_count;
  logic               w_do_push;
  logic               w_do_pop;

  // Admission is decided on the current count only, so a same-cycle pop never frees room for a push
  assign w_do_push = push & ~full;
  assign w_do_pop  = pop & ~empty;
  assign empty     = (r_count == '0);
  assign full      = (r_count == C_FULL);
  assign head      = r_mem[r_rd_ptr];

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + C_CNT_ONE;
        2'b01:   r_count <= r_count - C_CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk_sys) begin
    if (w_do_push) r_mem[r_wr_ptr] <= push_data;
  end

endmodule

`default_nettype wire

// File: rtl/bk_kbd_regs.sv
// ============================================================================
// bk_kbd_regs : BK keyboard registers 177660/177662, key FIFO and vector 60/274
// requests. Define KBD_OVERRUN_EN for the sticky overrun flag in bit 15.
// Rev 1.0
// ============================================================================
`default_nettype none

module bk_kbd_regs
  import bk_kbd_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ce_bus,
  input  logic        bus_sync,
  input  logic [15:0] bus_addr,
  input  logic        bus_we,
  input  logic [1:0]  bus_wtbt,
  input  logic        bus_stb,
  input  logic [15:0] bus_din,
  output logic [15:0] bus_dout,
  output logic        bus_ack,
  input  logic        key_valid,
  input  logic [6:0]  key_code,
  input  logic        key_ar2,
  output logic        key_ready,
  output logic        virq_req60,
  output logic        virq_req274,
  input  logic        virq_ack60,
  input  logic        virq_ack274
);

  logic       r_sel660;
  logic       r_sel662;
  logic       r_ack;
  logic       r_rd660;
  logic       r_rd662;
  logic       r_mask;
  logic       r_acked;
  logic       w_ovr_bit;
  logic       w_empty;
  logic       w_full;
  kbd_entry_t w_head;
  kbd_entry_t w_push_data;
  logic       w_push_ok;
  logic       w_pop;
  logic       w_rd660_done;
  logic       w_mask_wr;
  logic       w_req;
  logic       w_taken;
  logic       w_unused;

  assign w_push_data  = '{ar2: key_ar2, code: key_code};
  assign w_push_ok    = key_valid & ~w_full;
  assign w_pop        = r_rd662 & ~bus_stb;
  assign w_rd660_done = r_rd660 & ~bus_stb;
  assign w_mask_wr    = ce_bus & bus_stb & bus_we & r_sel660 & bus_wtbt[0];
  assign w_unused     = ^{bus_din[15:7], bus_din[5:0], bus_addr[0], bus_wtbt[1]};

  kbd_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_sys   (clk_sys),
    .reset_n   (reset_n),
    .push      (key_valid),
    .push_data (w_push_data),
    .pop       (w_pop),
    .head      (w_head),
    .empty     (w_empty),
    .full      (w_full)
  );

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_sel660 <= 1'b0;
      r_sel662 <= 1'b0;
      r_ack    <= 1'b0;
      r_rd660  <= 1'b0;
      r_rd662  <= 1'b0;
    end else begin
      if (!bus_sync) begin
        r_sel660 <= 1'b0;
        r_sel662 <= 1'b0;
      end else begin
        if (bus_addr[15:1] == KBD_CSR_ADDR[15:1])  r_sel660 <= 1'b1;
        if (bus_addr[15:1] == KBD_DATA_ADDR[15:1]) r_sel662 <= 1'b1;
      end
      if (ce_bus) begin
        if (bus_stb && (r_sel660 || r_sel662)) r_ack <= 1'b1;
        else if (!bus_stb)                     r_ack <= 1'b0;
      end
      // Read-in-progress flags; their fall marks the completion of the read
      if (!bus_stb) begin
        r_rd660 <= 1'b0;
        r_rd662 <= 1'b0;
      end else if (!bus_we) begin
        if (r_sel660) r_rd660 <= 1'b1;
        if (r_sel662) r_rd662 <= 1'b1;
      end
    end
  end

  // A request is live while a head exists, interrupts are enabled and this head is not yet taken
  assign w_req       = ~r_mask & ~w_empty & ~r_acked;
  assign virq_req60  = w_req & ~w_head.ar2;
  assign virq_req274 = w_req & w_head.ar2;
  assign w_taken     = (virq_ack60 & virq_req60) | (virq_ack274 & virq_req274);

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_mask  <= 1'b0;
      r_acked <= 1'b0;
    end else begin
      if (w_mask_wr) r_mask <= bus_din[6];
      if (w_pop || (w_push_ok && w_empty) || w_mask_wr) r_acked <= 1'b0;
      else if (w_taken)                                 r_acked <= 1'b1;
    end
  end

`ifdef KBD_OVERRUN_EN
  logic r_ovr;
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n)                  r_ovr <= 1'b0;
    else if (key_valid && w_full)  r_ovr <= 1'b1;
    else if (w_rd660_done)         r_ovr <= 1'b0;
  end
  assign w_ovr_bit = r_ovr;
`else
  assign w_ovr_bit = 1'b0;
`endif

  always_comb begin
    bus_dout = 16'h0000;
    if (r_sel660 && !bus_we)
      bus_dout = {w_ovr_bit, 7'b0, ~w_empty, r_mask, 6'b0};
    else if (r_sel662 && !bus_we && !w_empty)
      bus_dout = {9'b0, w_head.code};
  end

  assign bus_ack   = r_ack;
  assign key_ready = ~w_full;

endmodule

`default_nettype wire

// File: tb/tb_bk_kbd_regs.sv
// ============================================================================
// tb_bk_kbd_regs : directed and randomized checks of bk_kbd_regs against a
// queue-based model of the keyboard registers.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_bk_kbd_regs;
  import bk_kbd_pkg::*;

  localparam int DEPTH = 4;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        ce_bus = 1'b0;
  logic        bus_sync = 1'b0;
  logic [15:0] bus_addr = '0;
  logic        bus_we = 1'b0;
  logic [1:0]  bus_wtbt = '0;
  logic        bus_stb = 1'b0;
  logic [15:0] bus_din = '0;
  logic [15:0] bus_dout;
  logic        bus_ack;
  logic        key_valid = 1'b0;
  logic [6:0]  key_code = '0;
  logic        key_ar2 = 1'b0;
  logic        key_ready;
  logic        virq_req60;
  logic        virq_req274;
  logic        virq_ack60 = 1'b0;
  logic        virq_ack274 = 1'b0;

  int n_checks = 0;
  int n_fail = 0;

  logic [7:0] m_q[$];
  bit         m_mask = 1'b0;
  bit         m_pend = 1'b0;
  bit         m_ovr = 1'b0;

  bk_kbd_regs #(.FIFO_DEPTH(DEPTH)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .ce_bus(ce_bus), .bus_sync(bus_sync),
    .bus_addr(bus_addr), .bus_we(bus_we), .bus_wtbt(bus_wtbt), .bus_stb(bus_stb),
    .bus_din(bus_din), .bus_dout(bus_dout), .bus_ack(bus_ack), .key_valid(key_valid),
    .key_code(key_code), .key_ar2(key_ar2), .key_ready(key_ready),
    .virq_req60(virq_req60), .virq_req274(virq_req274),
    .virq_ack60(virq_ack60), .virq_ack274(virq_ack274)
  );

  always #5 clk_sys = ~clk_sys;
  always @(negedge clk_sys) ce_bus = ~ce_bus;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] exp_csr();
    logic ovr;
`ifdef KBD_OVERRUN_EN
    ovr = m_ovr;
`else
    ovr = 1'b0;
`endif
    return {ovr, 7'b0, (m_q.size() != 0), m_mask, 6'b0};
  endfunction

  function automatic logic [15:0] exp_data();
    return (m_q.size() != 0) ? {9'b0, m_q[0][6:0]} : 16'h0000;
  endfunction

  function automatic logic exp_req60();
    return m_pend && !m_mask && (m_q.size() != 0) && !m_q[0][7];
  endfunction

  function automatic logic exp_req274();
    return m_pend && !m_mask && (m_q.size() != 0) && m_q[0][7];
  endfunction

  task automatic push_key(input logic [7:0] ent);
    bit was_empty;
    @(negedge clk_sys);
    key_valid = 1'b1; key_code = ent[6:0]; key_ar2 = ent[7];
    @(negedge clk_sys);
    key_valid = 1'b0;
    if (m_q.size() < DEPTH) begin
      was_empty = (m_q.size() == 0);
      m_q.push_back(ent);
      if (was_empty && !m_mask) m_pend = 1'b1;
    end else begin
      m_ovr = 1'b1;
    end
  endtask

  task automatic pulse_ack(input bit v274);
    bit hit;
    hit = v274 ? exp_req274() : exp_req60();
    @(negedge clk_sys);
    if (v274) virq_ack274 = 1'b1; else virq_ack60 = 1'b1;
    @(negedge clk_sys);
    virq_ack274 = 1'b0; virq_ack60 = 1'b0;
    if (hit) m_pend = 1'b0;
  endtask

  // One complete bus cycle; optionally strobes key_valid on the clock where bus_stb falls
  task automatic bus_cycle(input logic [15:0] addr, input logic we, input logic [1:0] wtbt,
                           input logic [15:0] din, input bit kv_at_fall,
                           input logic [7:0] kv_ent, output logic [15:0] rdata);
    int t;
    int size_before;
    bit popped;
    bit pushed;
    @(negedge clk_sys);
    bus_sync = 1'b1; bus_addr = addr; bus_we = we; bus_wtbt = wtbt; bus_din = din;
    @(negedge clk_sys);
    bus_stb = 1'b1;
    t = 0;
    do begin @(negedge clk_sys); t++; end while (!bus_ack && t < 8);
    n_checks++;
    if (bus_ack !== 1'b1) begin
      n_fail++; $display("FAIL ack_rise addr=%o: bus_ack=%b required 1", addr, bus_ack);
    end
    rdata = bus_dout;
    bus_stb = 1'b0;
    if (kv_at_fall) begin key_valid = 1'b1; key_code = kv_ent[6:0]; key_ar2 = kv_ent[7]; end
    @(negedge clk_sys);
    key_valid = 1'b0;
    t = 0;
    while (bus_ack && t < 8) begin @(negedge clk_sys); t++; end
    n_checks++;
    if (bus_ack !== 1'b0) begin
      n_fail++; $display("FAIL ack_fall addr=%o: bus_ack=%b required 0", addr, bus_ack);
    end
    bus_sync = 1'b0;
    size_before = m_q.size();
    popped = 1'b0;
    pushed = 1'b0;
    if (!we && addr == KBD_DATA_ADDR && size_before > 0) begin
      void'(m_q.pop_front()); popped = 1'b1; m_pend = 1'b0;
    end
    if (!we && addr == KBD_CSR_ADDR) m_ovr = 1'b0;
    if (kv_at_fall) begin
      if (size_before < DEPTH) begin m_q.push_back(kv_ent); pushed = 1'b1; end
      else m_ovr = 1'b1;
    end
    if (we && addr == KBD_CSR_ADDR && wtbt[0]) begin
      m_mask = din[6];
      if (din[6]) m_pend = 1'b0;
      else if (m_q.size() != 0) m_pend = 1'b1;
    end
    if (!m_mask && m_q.size() != 0 && (popped || (size_before == 0 && pushed))) m_pend = 1'b1;
  endtask

  task automatic test_reset();
    logic [15:0] rd;
    @(negedge clk_sys);
    n_checks++; if (bus_ack !== 1'b0) begin n_fail++; $display("FAIL rst_ack: got %b required 0", bus_ack); end
    n_checks++; if (bus_dout !== 16'h0) begin n_fail++; $display("FAIL rst_dout: got %h required 0", bus_dout); end
    n_checks++; if (key_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b required 1", key_ready); end
    n_checks++; if ({virq_req60, virq_req274} !== 2'b00) begin n_fail++; $display("FAIL rst_req: got %b required 00", {virq_req60, virq_req274}); end
    bus_cycle(KBD_CSR_ADDR, 1'b0, 2'b00, 16'h0, 1'b0, 8'h0, rd);
    n_checks++; if (rd !== 16'h0) begin n_fail++; $display("FAIL rst_csr: got %o required 0", rd); end
  endtask

  task automatic test_basic();
    logic [15:0] rd;
    push_key({1'b0, 7'o101});
    bus_cycle(KBD_CSR_ADDR, 1'b0, 2'b00, 16'h0, 1'b0, 8'h0, rd);
    n_checks++; if (rd !== 16'o000200) begin n_fail++; $display("FAIL basic_csr: got %o required 000200", rd); end
    n_checks++; if (virq_req60 !== 1'b1) begin n_fail++; $display("FAIL basic_req60: got %b required 1", virq_req60); end
    bus_cycle(KBD_DATA_ADDR, 1'b0, 2'b00, 16'h0, 1'b0, 8'h0, rd);
    n_checks++; if (rd !== 16'o000101) begin n_fail++; $display("FAIL basic_data: got %o required 000101", rd); end
    n_checks++; if (virq_req60 !== 1'b0) begin n_fail++; $display("FAIL basic_req60_clr: got %b required 0", virq_req60); end
    bus_cycle(KBD_CSR_ADDR, 1'b0, 2'b00, 16'h0, 1'b0, 8'h0, rd);
    n_checks++; if (rd !== 16'o000000) begin n_fail++; $display("FAIL basic_rdy_clr: got %o required 0", rd); end
  endtask

  task automatic test_ar2();
    logic [15:0] rd;
    push_key({1'b1, 7'o012});
    @(negedge clk_sys);
    n_checks++; if ({virq_req60, virq_req274} !== 2'b01) begin n_fail++; $display("FAIL ar2_req: got %b required 01", {virq_req60, virq_req274}); end
    pulse_ack(1'b1);
    @(negedge clk_sys);
    n_checks++; if ({virq_req60, virq_req274} !== 2'b00) begin n_fail++; $display("FAIL ar2_ack: got %b required 00", {virq_req60, virq_req274}); end
    bus_cycle(KBD_DATA_ADDR, 1'b0, 2'b00, 16'h0, 1'b0, 8'h0, rd);
    n_checks++; if (rd !== 16'o000012) begin n_fail++; $display("FAIL ar2_data: got %o required 000012", rd); end
  endtask

  task automatic test_mask();
    logic [15:0] rd;
    bus_cycle(KBD_CSR_ADDR, 1'b1, 2'b11, 16'o000100, 1'b0, 8'h0, rd);
    push_key({1'b0, 7'o055});
    @(negedge clk_sys);
    n_checks++; if ({virq_req60, virq_req274} !== 2'b00) begin n_fail++; $display("FAIL mask_req: got %b required 00", {virq_req60, virq_req274}); end
    bus_cycle(KBD_CSR_ADDR, 1'b0, 2'b00, 16'h0, 1'b0, 8'h0, rd);
    n_checks++; if (rd !== 16'o000300) begin n_fail++; $display("FAIL mask_csr: got %o required 000300", rd); end
    bus_cycle(KBD_CSR_ADDR, 1'b1, 2'b10, 16'o000000, 1'b0, 8'h0, rd);
    n_checks++; if (virq_req60 !== 1'b0) begin n_fail++; $display("FAIL mask_hibyte: got req60=%b required 0", virq_req60); end
    bus_cycle(KBD_CSR_ADDR, 1'b1, 2'b01, 16'o000000, 1'b0, 8'h0, rd);
    n_checks++; if (virq_req60 !== 1'b1) begin n_fail++; $display("FAIL mask_unmask: got req60=%b required 1", virq_req60); end
    bus_cycle(KBD_DATA_ADDR, 1'b0, 2'b00, 16'h0, 1'b0, 8'h0, rd);
    n_checks++; if (rd !== 16'o000055) begin n_fail++; $display("FAIL mask_data: got %o required 000055", rd); end
  endtask

  task automatic test_overflow();
    logic [15:0] rd;
    for (int k = 1; k <= DEPTH + 1; k++) begin
      push_key(8'(k));
      n_checks++;
      if (key_ready !== (m_q.size() < DEPTH)) begin
        n_fail++; $display("FAIL ovf_ready k=%0d: got %b required %b", k, key_ready, (m_q.size() < DEPTH));
      end
    end
    bus_cycle(KBD_CSR_ADDR, 1'b0, 2'b00, 16'h0, 1'b0, 8'h0, rd);
`ifdef KBD_OVERRUN_EN
    n_checks++; if (rd !== 16'o100200) begin n_fail++; $display("FAIL ovf_csr: got %o required 100200", rd); end
`else
    n_checks++; if (rd !== 16'o000200) begin n_fail++; $display("FAIL ovf_csr: got %o required 000200", rd); end
`endif
    bus_cycle(KBD_CSR_ADDR, 1'b0, 2'b00, 16'h0, 1'b0, 8'h0, rd);
    n_checks++; if (rd !== 16'o000200) begin n_fail++; $display("FAIL ovf_csr_clr: got %o required 000200", rd); end
    for (int k = 1; k <= DEPTH; k++) begin
      bus_cycle(KBD_DATA_ADDR, 1'b0, 2'b00, 16'h0, 1'b0, 8'h0, rd);
      n_checks++; if (rd !== 16'(k)) begin n_fail++; $display("FAIL ovf_data k=%0d: got %o required %o", k, rd, 16'(k)); end
    end
    bus_cycle(KBD_CSR_ADDR, 1'b0, 2'b00, 16'h0, 1'b0, 8'h0, rd);
    n_checks++; if (rd !== 16'o000000) begin n_fail++; $display("FAIL ovf_empty: got %o required 0", rd); end
  endtask

  task automatic test_push_pop();
    logic [15:0] rd;
    push_key(8'h21);
    push_key(8'h22);
    bus_cycle(KBD_DATA_ADDR, 1'b0, 2'b00, 16'h0, 1'b1, 8'h23, rd);
    n_checks++; if (rd !== 16'h0021) begin n_fail++; $display("FAIL pp_first: got %h required 0021", rd); end
    n_checks++; if (key_ready !== 1'b1) begin n_fail++; $display("FAIL pp_ready: got %b required 1", key_ready); end
    bus_cycle(KBD_DATA_ADDR, 1'b0, 2'b00, 16'h0, 1'b0, 8'h0, rd);
    n_checks++; if (rd !== 16'h0022) begin n_fail++; $display("FAIL pp_second: got %h required 0022", rd); end
    bus_cycle(KBD_DATA_ADDR, 1'b0, 2'b00, 16'h0, 1'b0, 8'h0, rd);
    n_checks++; if (rd !== 16'h0023) begin n_fail++; $display("FAIL pp_third: got %h required 0023", rd); end
    bus_cycle(KBD_CSR_ADDR, 1'b0, 2'b00, 16'h0, 1'b0, 8'h0, rd);
    n_checks++; if (rd !== 16'h0000) begin n_fail++; $display("FAIL pp_empty: got %o required 0", rd); end
  endtask

  task automatic test_random();
    logic [15:0] rd;
    logic [15:0] ex;
    int op;
    for (int i = 0; i < 150; i++) begin
      op = $urandom_range(0, 5);
      case (op)
        0, 1: push_key(8'($urandom));
        2: begin
          ex = exp_data();
          bus_cycle(KBD_DATA_ADDR, 1'b0, 2'b00, 16'h0, 1'b0, 8'h0, rd);
          n_checks++; if (rd !== ex) begin n_fail++; $display("FAIL rnd_data i=%0d: got %o required %o", i, rd, ex); end
        end
        3: begin
          ex = exp_csr();
          bus_cycle(KBD_CSR_ADDR, 1'b0, 2'b00, 16'h0, 1'b0, 8'h0, rd);
          n_checks++; if (rd !== ex) begin n_fail++; $display("FAIL rnd_csr i=%0d: got %o required %o", i, rd, ex); end
        end
        4: bus_cycle(KBD_CSR_ADDR, 1'b1, 2'($urandom),
                     ($urandom_range(0, 3) == 0) ? 16'o000100 : 16'o000000, 1'b0, 8'h0, rd);
        default: begin
          if (exp_req60() || exp_req274()) pulse_ack(exp_req274());
          else bus_cycle(KBD_DATA_ADDR, 1'b1, 2'b11, 16'($urandom), 1'b0, 8'h0, rd);
        end
      endcase
      @(negedge clk_sys);
      n_checks++;
      if ({virq_req60, virq_req274, key_ready} !== {exp_req60(), exp_req274(), (m_q.size() < DEPTH)}) begin
        n_fail++;
        $display("FAIL rnd_state i=%0d op=%0d: got req60/req274/ready=%b%b%b required %b%b%b", i, op,
                 virq_req60, virq_req274, key_ready, exp_req60(), exp_req274(), (m_q.size() < DEPTH));
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] rd;
    int t;
    if (m_q.size() == 0) push_key(8'h05);
    @(negedge clk_sys);
    bus_sync = 1'b1; bus_addr = KBD_DATA_ADDR; bus_we = 1'b0; bus_wtbt = 2'b00;
    @(negedge clk_sys);
    bus_stb = 1'b1;
    t = 0;
    do begin @(negedge clk_sys); t++; end while (!bus_ack && t < 8);
    n_checks++; if (bus_ack !== 1'b1) begin n_fail++; $display("FAIL mid_ack_rise: got %b required 1", bus_ack); end
    reset_n = 1'b0;
    #1;
    n_checks++; if (bus_ack !== 1'b0) begin n_fail++; $display("FAIL mid_ack: got %b required 0", bus_ack); end
    n_checks++; if ({virq_req60, virq_req274} !== 2'b00) begin n_fail++; $display("FAIL mid_req: got %b required 00", {virq_req60, virq_req274}); end
    n_checks++; if (key_ready !== 1'b1) begin n_fail++; $display("FAIL mid_ready: got %b required 1", key_ready); end
    n_checks++; if (bus_dout !== 16'h0) begin n_fail++; $display("FAIL mid_dout: got %o required 0", bus_dout); end
    @(negedge clk_sys);
    bus_stb = 1'b0; bus_sync = 1'b0;
    @(negedge clk_sys);
    reset_n = 1'b1;
    m_q.delete(); m_mask = 1'b0; m_pend = 1'b0; m_ovr = 1'b0;
    bus_cycle(KBD_DATA_ADDR, 1'b0, 2'b00, 16'h0, 1'b0, 8'h0, rd);
    n_checks++; if (rd !== 16'h0) begin n_fail++; $display("FAIL mid_stale: got %o required 0", rd); end
    bus_cycle(KBD_CSR_ADDR, 1'b0, 2'b00, 16'h0, 1'b0, 8'h0, rd);
    n_checks++; if (rd !== 16'h0) begin n_fail++; $display("FAIL mid_csr: got %o required 0", rd); end
  endtask

  initial begin
    repeat (3) @(negedge clk_sys);
    reset_n = 1'b1;
    test_reset();
    test_basic();
    test_ar2();
    test_mask();
    test_overflow();
    test_push_pop();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
